// File: rtl/vram_text_writer.sv
// Writer side of the text-mode video RAM: accepts a character stream, writes it at a
// hardware cursor, and sequences scroll/clear operations through its own RAM port.
//
// state   | meaning
// IDLE    | ready for a character
// PUT     | single post-accept cycle; carries the cell write when the code produced one
// SCR_RD  | scroll: read cell one row below ptr
// SCR_WR  | scroll: write the read data back at ptr
// CLR_ROW | blank the bottom row after a scroll
// CLR_ALL | blank the whole screen (after reset or form feed)
module vram_text_writer #(
  parameter int          COLS  = 32,
  parameter int          ROWS  = 50,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic [10:0] v_ram_a,
  output logic [7:0]  v_ram_do,
  output logic        v_ram_we,
  input  logic [7:0]  v_ram_di,
  output logic [4:0]  cur_col,
  output logic [5:0]  cur_row,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUT     = 3'd1,
    SCR_RD  = 3'd2,
    SCR_WR  = 3'd3,
    CLR_ROW = 3'd4,
    CLR_ALL = 3'd5
  } state_t;

  localparam logic [10:0] LAST_ADDR     = 11'(ROWS * COLS - 1);
  localparam logic [10:0] COPY_LAST     = 11'((ROWS - 1) * COLS - 1);
  localparam logic [10:0] LAST_ROW_BASE = 11'((ROWS - 1) * COLS);
  localparam logic [10:0] COLS_A        = 11'(COLS);
  localparam logic [4:0]  COL_MAX       = 5'(COLS - 1);
  localparam logic [5:0]  ROW_MAX       = 6'(ROWS - 1);
  localparam int          CSH           = $clog2(COLS);
  localparam bit          COLS_POW2     = ((1 << CSH) == COLS);

  state_t      r_state, w_state_nxt;
  logic [10:0] r_ptr, w_ptr_nxt;
  logic [4:0]  r_col, w_col_nxt;
  logic [5:0]  r_row, w_row_nxt;
  logic        r_scroll, w_scroll_nxt;
  logic [10:0] r_a, w_a_nxt;
  logic [7:0]  r_do, w_do_nxt;
  logic        r_we, w_we_nxt;
  logic [10:0] w_row_base;
  logic [10:0] w_cur_addr;

  generate
    if (COLS_POW2) begin : g_row_shift
      assign w_row_base = 11'(r_row) << CSH;
    end else begin : g_row_mul
      assign w_row_base = 11'(r_row) * COLS_A;
    end
  endgenerate

  assign w_cur_addr = w_row_base + 11'(r_col);

  assign ch_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign v_ram_a  = r_a;
  assign v_ram_we = r_we;
  // Synchronous RAM data only arrives in the SCR_WR cycle itself, so it is forwarded.
  assign v_ram_do = (r_state == SCR_WR) ? v_ram_di : r_do;
  assign cur_col  = r_col;
  assign cur_row  = r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CLR_ALL;
      r_ptr    <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_scroll <= 1'b0;
      r_a      <= '0;
      r_do     <= BLANK;
      r_we     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_col    <= w_col_nxt;
      r_row    <= w_row_nxt;
      r_scroll <= w_scroll_nxt;
      r_a      <= w_a_nxt;
      r_do     <= w_do_nxt;
      r_we     <= w_we_nxt;
    end
  end

  // Bus registers are loaded with the values of the state being entered, except
  // CLR_ALL whose writes trail ptr by one cycle so reset can leave we low.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_scroll_nxt = r_scroll;
    w_a_nxt      = r_a;
    w_do_nxt     = BLANK;
    w_we_nxt     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ch_valid) begin
          w_state_nxt = PUT;
          if (ch_data >= 8'h20) begin
            w_we_nxt = 1'b1;
            w_a_nxt  = w_cur_addr;
            w_do_nxt = ch_data;
            if (r_col < COL_MAX) begin
              w_col_nxt = r_col + 5'd1;
            end else begin
              w_col_nxt = '0;
              if (r_row < ROW_MAX) w_row_nxt = r_row + 6'd1;
              else                 w_scroll_nxt = 1'b1;
            end
          end else begin
            case (ch_data)
              8'h0D: w_col_nxt = '0;
              8'h0A: begin
                w_col_nxt = '0;
                if (r_row < ROW_MAX) begin
                  w_row_nxt = r_row + 6'd1;
                end else begin
                  w_state_nxt = SCR_RD;
                  w_ptr_nxt   = '0;
                  w_a_nxt     = COLS_A;
                end
              end
              8'h08: begin
                if (r_col != 5'd0) begin
                  w_col_nxt = r_col - 5'd1;
                  w_we_nxt  = 1'b1;
                  w_a_nxt   = w_cur_addr - 11'd1;
                end
              end
              8'h0C: begin
                w_state_nxt = CLR_ALL;
                w_ptr_nxt   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        if (r_scroll) begin
          w_state_nxt  = SCR_RD;
          w_ptr_nxt    = '0;
          w_a_nxt      = COLS_A;
          w_scroll_nxt = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCR_RD: begin
        w_state_nxt = SCR_WR;
        w_a_nxt     = r_ptr;
        w_we_nxt    = 1'b1;
      end
      SCR_WR: begin
        if (r_ptr == COPY_LAST) begin
          w_state_nxt = CLR_ROW;
          w_ptr_nxt   = LAST_ROW_BASE;
          w_a_nxt     = LAST_ROW_BASE;
          w_we_nxt    = 1'b1;
        end else begin
          w_state_nxt = SCR_RD;
          w_ptr_nxt   = r_ptr + 11'd1;
          w_a_nxt     = r_ptr + 11'd1 + COLS_A;
        end
      end
      CLR_ROW: begin
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = IDLE;
        end else begin
          w_ptr_nxt = r_ptr + 11'd1;
          w_a_nxt   = r_ptr + 11'd1;
          w_we_nxt  = 1'b1;
        end
      end
      CLR_ALL: begin
        w_a_nxt  = r_ptr;
        w_we_nxt = 1'b1;
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 11'd1;
        end
      end
      default: begin
        w_state_nxt = CLR_ALL;
        w_ptr_nxt   = '0;
      end
    endcase
  end

endmodule
